alu_control_unit: RTL

Hardwired Moore control unit that sequences the CPU datapath through instruction fetch and register-register ALU execution. It reads the instruction register (IR) and drives every register enable, bus-source select, ALU operation strobe, `Read` and `IncPC` input of the datapath. All sequencing is one state per `clk` cycle. It replaces testbench-driven T0..Tn stimulus for ALU-class instructions.

---
 rtl/alu_control_unit_if.sv | 73 +++++++
 rtl/alu_control_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_unit_if.sv
// Control bundle between the hardwired ALU control unit and the datapath.
// master: controller (drives strobes/selects); slave: datapath (drives IR, stop).
interface alu_control_unit_if;
  logic        stop;
  logic [31:0] IR;

  logic [15:0] Rin;
  logic [15:0] Rout;

  logic HIin;
  logic LOin;
  logic PCin;
  logic IRin;
  logic Zin;
  logic Yin;
  logic MARin;
  logic MDRin;

  logic HIout;
  logic LOout;
  logic Zhighout;
  logic Zlowout;
  logic PCout;
  logic MDRout;

  logic Read;
  logic IncPC;

  logic AND;
  logic OR;
  logic ADD;
  logic SUB;
  logic MUL;
  logic DIV;
  logic SHR;
  logic SHRA;
  logic SHL;
  logic ROR;
  logic ROL;
  logic NEG;
  logic NOT;

  logic       run;
  logic [3:0] state;

  modport master (
    input  stop, IR,
    output Rin, Rout,
    output HIin, LOin, PCin, IRin,
    output Zin, Yin, MARin, MDRin,
    output HIout, LOout, Zhighout,
    output Zlowout, PCout, MDRout,
    output Read, IncPC,
    output AND, OR, ADD, SUB, MUL,
    output DIV, SHR, SHRA, SHL,
    output ROR, ROL, NEG, NOT,
    output run, state
  );

  modport slave (
    output stop, IR,
    input  Rin, Rout,
    input  HIin, LOin, PCin, IRin,
    input  Zin, Yin, MARin, MDRin,
    input  HIout, LOout, Zhighout,
    input  Zlowout, PCout, MDRout,
    input  Read, IncPC,
    input  AND, OR, ADD, SUB, MUL,
    input  DIV, SHR, SHRA, SHL,
    input  ROR, ROL, NEG, NOT,
    input  run, state
  );
endinterface

// File: rtl/alu_control_unit.sv
// Hardwired Moore controller: fetch + reg-reg ALU execute, one state/cycle.
// Ports: clk, reset (sync, active-high), bus (master: stop/IR in, controls out).
module alu_control_unit (
  input  logic              clk,
  input  logic              reset,
  alu_control_unit_if.master bus
);

  localparam logic [3:0] S_RESET = 4'd0;
  localparam logic [3:0] S_T0    = 4'd1;
  localparam logic [3:0] S_T1    = 4'd2;
  localparam logic [3:0] S_T2    = 4'd3;
  localparam logic [3:0] S_T3    = 4'd4;
  localparam logic [3:0] S_T4    = 4'd5;
  localparam logic [3:0] S_T5    = 4'd6;
  localparam logic [3:0] S_T6    = 4'd7;
  localparam logic [3:0] S_HALT  = 4'd8;
  localparam logic [3:0] S_IDLE  = 4'd9;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic [3:0] w_bnd;

  logic [4:0] w_opc;
  logic [3:0] w_ra;
  logic [3:0] w_rb;
  logic [3:0] w_rc;

  logic w_two;
  logic w_md;
  logic w_un;
  logic w_halt;
  logic w_stb;

  logic w_unused;

  assign w_opc = bus.IR[31:27];
  assign w_ra  = bus.IR[26:23];
  assign w_rb  = bus.IR[22:19];
  assign w_rc  = bus.IR[18:15];

  assign w_unused = ^bus.IR[14:0];

  // Instruction class decode
  always_comb begin
    w_two  = 1'b0;
    w_md   = 1'b0;
    w_un   = 1'b0;
    w_halt = 1'b0;
    case (w_opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_ROR, OP_ROL, OP_SHR, OP_SHRA,
      OP_SHL:           w_two  = 1'b1;
      OP_MUL, OP_DIV:   w_md   = 1'b1;
      OP_NEG, OP_NOT:   w_un   = 1'b1;
      OP_HALT:          w_halt = 1'b1;
      default:          ;
    endcase
  end

  // Instruction boundary target: IDLE swallows the fetch while stop is held
  assign w_bnd = bus.stop ? S_IDLE : S_T0;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_RESET;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = S_RESET;
    case (r_state)
      S_RESET: w_next = w_bnd;
      S_T0:    w_next = S_T1;
      S_T1:    w_next = S_T2;
      S_T2: begin
        if (w_two | w_md | w_un) w_next = S_T3;
        else if (w_halt)         w_next = S_HALT;
        else                     w_next = w_bnd;
      end
      S_T3:    w_next = S_T4;
      S_T4:    w_next = w_un ? w_bnd : S_T5;
      S_T5:    w_next = w_md ? S_T6 : w_bnd;
      S_T6:    w_next = w_bnd;
      S_HALT:  w_next = S_HALT;
      S_IDLE:  w_next = w_bnd;
      default: w_next = S_RESET;
    endcase
  end

  always_comb begin
    bus.Rin      = '0;
    bus.Rout     = '0;
    bus.HIin     = 1'b0;
    bus.LOin     = 1'b0;
    bus.PCin     = 1'b0;
    bus.IRin     = 1'b0;
    bus.Zin      = 1'b0;
    bus.Yin      = 1'b0;
    bus.MARin    = 1'b0;
    bus.MDRin    = 1'b0;
    bus.HIout    = 1'b0;
    bus.LOout    = 1'b0;
    bus.Zhighout = 1'b0;
    bus.Zlowout  = 1'b0;
    bus.PCout    = 1'b0;
    bus.MDRout   = 1'b0;
    bus.Read     = 1'b0;
    bus.IncPC    = 1'b0;
    bus.run      = 1'b1;
    w_stb        = 1'b0;
    case (r_state)
      S_T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.Zin   = 1'b1;
      end
      S_T1: begin
        bus.Zlowout = 1'b1;
        bus.PCin    = 1'b1;
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
      end
      S_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      S_T3: begin
        if (w_two | w_md) begin
          bus.Rout = 16'h0001 << w_rb;
          bus.Yin  = 1'b1;
        end else if (w_un) begin
          bus.Rout = 16'h0001 << w_rb;
          bus.Zin  = 1'b1;
          w_stb    = 1'b1;
        end
      end
      S_T4: begin
        if (w_two | w_md) begin
          bus.Rout = 16'h0001 << w_rc;
          bus.Zin  = 1'b1;
          w_stb    = 1'b1;
        end else if (w_un) begin
          bus.Zlowout = 1'b1;
          bus.Rin     = 16'h0001 << w_ra;
        end
      end
      S_T5: begin
        if (w_two) begin
          bus.Zlowout = 1'b1;
          bus.Rin     = 16'h0001 << w_ra;
        end else if (w_md) begin
          bus.Zlowout = 1'b1;
          bus.LOin    = 1'b1;
        end
      end
      S_T6: begin
        if (w_md) begin
          bus.Zhighout = 1'b1;
          bus.HIin     = 1'b1;
        end
      end
      S_HALT:  bus.run = 1'b0;
      default: ;
    endcase
  end

  // One-hot ALU strobe, gated by the execute cycle that owns it
  always_comb begin
    bus.AND  = 1'b0;
    bus.OR   = 1'b0;
    bus.ADD  = 1'b0;
    bus.SUB  = 1'b0;
    bus.MUL  = 1'b0;
    bus.DIV  = 1'b0;
    bus.SHR  = 1'b0;
    bus.SHRA = 1'b0;
    bus.SHL  = 1'b0;
    bus.ROR  = 1'b0;
    bus.ROL  = 1'b0;
    bus.NEG  = 1'b0;
    bus.NOT  = 1'b0;
    if (w_stb) begin
      case (w_opc)
        OP_ADD:  bus.ADD  = 1'b1;
        OP_SUB:  bus.SUB  = 1'b1;
        OP_AND:  bus.AND  = 1'b1;
        OP_OR:   bus.OR   = 1'b1;
        OP_ROR:  bus.ROR  = 1'b1;
        OP_ROL:  bus.ROL  = 1'b1;
        OP_SHR:  bus.SHR  = 1'b1;
        OP_SHRA: bus.SHRA = 1'b1;
        OP_SHL:  bus.SHL  = 1'b1;
        OP_MUL:  bus.MUL  = 1'b1;
        OP_DIV:  bus.DIV  = 1'b1;
        OP_NEG:  bus.NEG  = 1'b1;
        OP_NOT:  bus.NOT  = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.state = r_state;

endmodule
